// File: rtl/cam_pkg.sv
// Shared sizes and FSM state encoding for the CAM lookup engine.
// Feature macro: CAM_LOOKUP_AUTO_ALLOC_EN (miss allocation) is consumed in cam_lookup_engine.sv.
package cam_pkg;

  localparam int CAM_DEPTH = 32;
  localparam int CAM_WIDTH = 32;
  localparam int CAM_IDX_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_EVAL   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } cam_state_e;

endpackage

// File: rtl/cam_alloc_ptr.sv
// Round-robin allocation pointer plus saturating occupancy counter.
// The pointer wraps past the last entry, so once the CAM is full the
// oldest installed entry is always the next one overwritten.
module cam_alloc_ptr
  import cam_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 adv_i,
  output logic [CAM_IDX_W-1:0] ptr_o,
  output logic [CAM_IDX_W:0]   occupancy_o,
  output logic                 full_o
);

  logic [CAM_IDX_W-1:0] ptr_q;
  logic [CAM_IDX_W:0]   occ_q;
  logic                 full;

  assign full = (occ_q == (CAM_IDX_W + 1)'(CAM_DEPTH));

  // Advance pointer and count installs; occupancy saturates at depth.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      ptr_q <= '0;
      occ_q <= '0;
    end else if (adv_i) begin
      ptr_q <= ptr_q + CAM_IDX_W'(1);
      if (!full) occ_q <= occ_q + (CAM_IDX_W + 1)'(1);
    end
  end

  assign ptr_o       = ptr_q;
  assign occupancy_o = occ_q;
  assign full_o      = full;

endmodule

// File: rtl/cam_lookup_engine.sv
// Lookup engine sitting in front of an external CAM: searches for a key,
// reports hit/index, and on a miss optionally installs the key.
// Feature macro: CAM_LOOKUP_AUTO_ALLOC_EN -- when defined, misses allocate an
// entry (FIFO replacement); when undefined, misses just report index 0 and
// the write port, occupancy and full flag are tied low.
//
// state  | meaning
// IDLE   | ready for a request
// SEARCH | search issued to CAM with key_q
// EVAL   | CAM result sampled, hit/miss decided
// WRITE  | key_q written at alloc pointer (allocation builds only)
// RESP   | response held until consumer accepts
module cam_lookup_engine
  import cam_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [CAM_WIDTH-1:0] req_key_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [CAM_IDX_W-1:0] rsp_index_o,
  output logic [CAM_IDX_W:0]   occupancy_o,
  output logic                 full_o,
  output logic                 cam_search_enable_o,
  output logic [CAM_WIDTH-1:0] cam_search_data_o,
  input  logic                 cam_search_valid_i,
  input  logic [CAM_IDX_W-1:0] cam_search_index_i,
  output logic                 cam_write_enable_o,
  output logic [CAM_IDX_W-1:0] cam_write_index_o,
  output logic [CAM_WIDTH-1:0] cam_write_data_o
);

  cam_state_e           state_q, state_d;
  logic [CAM_WIDTH-1:0] key_q;
  logic                 rsp_hit_q;
  logic [CAM_IDX_W-1:0] rsp_index_q;
  logic [CAM_IDX_W-1:0] alloc_ptr;
  logic [CAM_IDX_W:0]   alloc_occ;
  logic                 alloc_full;
  logic                 search_act;

  cam_alloc_ptr u_alloc (
    .clk         (clk),
    .rst_i       (rst_i),
    .adv_i       (state_q == ST_WRITE),
    .ptr_o       (alloc_ptr),
    .occupancy_o (alloc_occ),
    .full_o      (alloc_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid_i) state_d = ST_SEARCH;
      ST_SEARCH: state_d = ST_EVAL;
      ST_EVAL: begin
        if (cam_search_valid_i) state_d = ST_RESP;
`ifdef CAM_LOOKUP_AUTO_ALLOC_EN
        else state_d = ST_WRITE;
`else
        else state_d = ST_RESP;
`endif
      end
      ST_WRITE:  state_d = ST_RESP;
      ST_RESP:   if (rsp_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Key capture and response fields, held stable through RESP.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      key_q       <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid_i) key_q <= req_key_i;
        ST_EVAL: begin
          rsp_hit_q   <= cam_search_valid_i;
          rsp_index_q <= cam_search_valid_i ? cam_search_index_i : '0;
        end
`ifdef CAM_LOOKUP_AUTO_ALLOC_EN
        ST_WRITE: begin
          rsp_hit_q   <= 1'b0;
          rsp_index_q <= alloc_ptr;
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; CAM strobes are masked by reset so a write
  // in flight when reset arrives never reaches the CAM.
  always_comb begin
    req_ready_o         = (state_q == ST_IDLE);
    rsp_valid_o         = (state_q == ST_RESP);
    search_act          = ((state_q == ST_SEARCH) || (state_q == ST_EVAL)) && !rst_i;
    cam_search_enable_o = search_act;
    cam_search_data_o   = search_act ? key_q : '0;
`ifdef CAM_LOOKUP_AUTO_ALLOC_EN
    cam_write_enable_o  = (state_q == ST_WRITE) && !rst_i;
    cam_write_index_o   = cam_write_enable_o ? alloc_ptr : '0;
    cam_write_data_o    = cam_write_enable_o ? key_q : '0;
`else
    cam_write_enable_o  = 1'b0;
    cam_write_index_o   = '0;
    cam_write_data_o    = '0;
`endif
  end

  assign rsp_hit_o   = rsp_hit_q;
  assign rsp_index_o = rsp_index_q;

`ifdef CAM_LOOKUP_AUTO_ALLOC_EN
  assign occupancy_o = alloc_occ;
  assign full_o      = alloc_full;
`else
  logic unused_alloc;
  assign unused_alloc = ^{alloc_ptr, alloc_occ, alloc_full};
  assign occupancy_o  = '0;
  assign full_o       = 1'b0;
`endif

endmodule

// File: tb/tb_cam_lookup_engine.sv
// Directed bench for cam_lookup_engine with a behavioural CAM alongside.
// Honours CAM_LOOKUP_AUTO_ALLOC_EN the same way the design does.
module tb_cam_lookup_engine;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_key_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic        rsp_hit_o;
  logic [4:0]  rsp_index_o;
  logic [5:0]  occupancy_o;
  logic        full_o;
  logic        cam_search_enable_o;
  logic [31:0] cam_search_data_o;
  logic        cam_search_valid_i;
  logic [4:0]  cam_search_index_i;
  logic        cam_write_enable_o;
  logic [4:0]  cam_write_index_o;
  logic [31:0] cam_write_data_o;

  always #5 clk = ~clk;

  cam_lookup_engine dut (
    .clk                 (clk),
    .rst_i               (rst_i),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_key_i           (req_key_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_ready_i         (rsp_ready_i),
    .rsp_hit_o           (rsp_hit_o),
    .rsp_index_o         (rsp_index_o),
    .occupancy_o         (occupancy_o),
    .full_o              (full_o),
    .cam_search_enable_o (cam_search_enable_o),
    .cam_search_data_o   (cam_search_data_o),
    .cam_search_valid_i  (cam_search_valid_i),
    .cam_search_index_i  (cam_search_index_i),
    .cam_write_enable_o  (cam_write_enable_o),
    .cam_write_index_o   (cam_write_index_o),
    .cam_write_data_o    (cam_write_data_o)
  );

  // Behavioural CAM: registered search result one cycle after issue, lowest
  // matching index wins. Contents survive rst_i; cam_clr empties it.
  logic [31:0] cam_key [32];
  logic [31:0] cam_vld = '0;
  logic        cam_clr = 1'b0;
  logic        pre_en = 1'b0;
  logic [4:0]  pre_idx = '0;
  logic [31:0] pre_key = '0;

  always @(posedge clk) begin
    if (rst_i) begin
      cam_search_valid_i <= 1'b0;
      cam_search_index_i <= '0;
    end else if (cam_search_enable_o) begin
      cam_search_valid_i <= 1'b0;
      cam_search_index_i <= '0;
      for (int i = 31; i >= 0; i--)
        if (cam_vld[i] && cam_key[i] == cam_search_data_o) begin
          cam_search_valid_i <= 1'b1;
          cam_search_index_i <= 5'(i);
        end
    end else begin
      cam_search_valid_i <= 1'b0;
    end
    if (cam_clr) begin
      cam_vld <= '0;
    end else begin
      if (cam_write_enable_o) begin
        cam_key[cam_write_index_o] <= cam_write_data_o;
        cam_vld[cam_write_index_o] <= 1'b1;
      end
      if (pre_en) begin
        cam_key[pre_idx] <= pre_key;
        cam_vld[pre_idx] <= 1'b1;
      end
    end
  end

  int wr_cnt = 0;
  int overlap_cnt = 0;
  always @(posedge clk) begin
    if (cam_write_enable_o) wr_cnt++;
    if (cam_write_enable_o && cam_search_enable_o) overlap_cnt++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic clear_cam();
    @(negedge clk);
    cam_clr = 1'b1;
    @(negedge clk);
    cam_clr = 1'b0;
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] key);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_key = key;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!req_ready_o && guard < 50) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Latency counts clock edges from the accept edge (1) to the edge after
  // which rsp_valid_o is first seen.
  task automatic lookup(input logic [31:0] key, output logic hit, output logic [4:0] idx,
                        output int lat, output logic [31:0] sdata);
    int guard;
    @(negedge clk);
    req_key_i = key;
    req_valid_i = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    lat = 1;
    @(negedge clk);
    sdata = cam_search_data_o;
    guard = 0;
    while (!rsp_valid_o && guard < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      guard++;
    end
    chk("resp_seen", rsp_valid_o, 1'b1);
    hit = rsp_hit_o;
    idx = rsp_index_o;
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
  endtask

  logic        hit;
  logic [4:0]  idx;
  int          lat;
  logic [31:0] sdata;
  int          wr_before;
  int          guard;

  initial begin
    do_reset();
    chk("rst_req_ready", req_ready_o, 1'b1);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_fields", {rsp_hit_o, rsp_index_o}, 6'd0);
    chk("rst_occ_full", {occupancy_o, full_o}, 7'd0);
    chk("rst_search", {cam_search_enable_o, cam_search_data_o}, 33'd0);
    chk("rst_write", {cam_write_enable_o, cam_write_index_o, cam_write_data_o}, 38'd0);

`ifdef CAM_LOOKUP_AUTO_ALLOC_EN
    lookup(32'hDEADBEEF, hit, idx, lat, sdata);
    chk("beef_miss", hit, 1'b0);
    chk("beef_idx", idx, 5'd0);
    chk("beef_lat", lat, 4);
    chk("beef_sdata", sdata, 32'hDEADBEEF);
    chk("beef_occ", occupancy_o, 6'd1);
    wr_before = wr_cnt;
    lookup(32'hDEADBEEF, hit, idx, lat, sdata);
    chk("beef2_hit", hit, 1'b1);
    chk("beef2_idx", idx, 5'd0);
    chk("beef2_lat", lat, 3);
    chk("beef2_nowrite", wr_cnt - wr_before, 0);
    chk("beef2_occ", occupancy_o, 6'd1);

    clear_cam();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      lookup(32'h100 + 32'(k), hit, idx, lat, sdata);
      chk("fill_hit_idx", {hit, idx}, {1'b0, 5'(k)});
    end
    chk("fill_full", {full_o, occupancy_o}, {1'b1, 6'd32});
    lookup(32'h200, hit, idx, lat, sdata);
    chk("evict_200", {hit, idx}, {1'b0, 5'd0});
    chk("evict_occ", occupancy_o, 6'd32);
    lookup(32'h100, hit, idx, lat, sdata);
    chk("evicted_100", {hit, idx}, {1'b0, 5'd1});
    lookup(32'h102, hit, idx, lat, sdata);
    chk("kept_102", {hit, idx, 4'(lat)}, {1'b1, 5'd2, 4'd3});

    // Reset landing on the WRITE cycle must abort the CAM write.
    @(negedge clk);
    req_key_i = 32'h55;
    req_valid_i = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!cam_write_enable_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("write_seen", cam_write_enable_o, 1'b1);
    rst_i = 1'b1;
    #1 chk("rst_write_abort", cam_write_enable_o, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;
    chk("rst_mid_occ", occupancy_o, 6'd0);
    chk("rst_mid_state", {req_ready_o, rsp_valid_o, rsp_hit_o, rsp_index_o}, 8'b1000_0000);
    lookup(32'h55, hit, idx, lat, sdata);
    chk("after_abort_miss", {hit, idx}, {1'b0, 5'd0});
    chk("after_abort_occ", occupancy_o, 6'd1);
`else
    lookup(32'h1234, hit, idx, lat, sdata);
    chk("noalloc_miss", hit, 1'b0);
    chk("noalloc_idx", idx, 5'd0);
    chk("noalloc_lat", lat, 3);
    chk("noalloc_sdata", sdata, 32'h1234);
    chk("noalloc_occ", {occupancy_o, full_o}, 7'd0);
    lookup(32'h1234, hit, idx, lat, sdata);
    chk("noalloc_again", {hit, idx}, 6'd0);
`endif

    // Hit path and back-pressure using a directly installed entry.
    clear_cam();
    do_reset();
    preload(5'd7, 32'hCAFEF00D);
    wr_before = wr_cnt;
    lookup(32'hCAFEF00D, hit, idx, lat, sdata);
    chk("pre_hit", {hit, idx}, {1'b1, 5'd7});
    chk("pre_lat", lat, 3);
    chk("pre_sdata", sdata, 32'hCAFEF00D);
    chk("pre_nowrite", wr_cnt - wr_before, 0);

    @(negedge clk);
    req_key_i = 32'hCAFEF00D;
    req_valid_i = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 req_key_i = 32'h77;
    guard = 0;
    @(negedge clk);
    while (!rsp_valid_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("stall_resp_seen", rsp_valid_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {rsp_valid_o, req_ready_o, cam_search_enable_o, rsp_hit_o, rsp_index_o},
          {1'b1, 1'b0, 1'b0, 1'b1, 5'd7});
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b0;
    @(posedge clk);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk);
    chk("after_hs", {rsp_valid_o, req_ready_o}, 2'b01);

    chk("no_overlap", overlap_cnt, 0);
`ifndef CAM_LOOKUP_AUTO_ALLOC_EN
    chk("noalloc_never_write", wr_cnt, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cam_lookup_engine.md
CAM_LOOKUP_ENGINE -- requirements
Module: cam_lookup_engine

Interface
REQ-001 Parameters: none; sizes SHALL come from cam_pkg constants CAM_DEPTH (32), CAM_WIDTH (32) and CAM_IDX_W (5).
REQ-002 One clock; reset is synchronous and active-high. The ports SHALL be as follows, clock and reset first:
- clk  in  1  sole clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  lookup request valid
- req_ready_o  out  1  engine can accept a request
- req_key_i  in  32  key to look up
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_hit_o  out  1  1 = key was already present
- rsp_index_o  out  5  matching or newly allocated entry index
- occupancy_o  out  6  valid entries installed, 0..32
- full_o  out  1  occupancy_o == 32
- cam_search_enable_o  out  1  drives CAM search_enable_i
- cam_search_data_o  out  32  drives CAM search_data_i
- cam_search_valid_i  in  1  from CAM search_valid_o
- cam_search_index_i  in  5  from CAM search_index_o
- cam_write_enable_o  out  1  drives CAM write_enable_i
- cam_write_index_o  out  5  drives CAM write_index_i
- cam_write_data_o  out  32  drives CAM write_data_i

Function
REQ-003 FSM states SHALL be IDLE, SEARCH, EVAL, WRITE and RESP; one transition at most per clk edge.
REQ-004 IDLE: req_ready_o=1; on req_valid_i&&req_ready_o, the engine SHALL register req_key_i into key_q and go to SEARCH.
REQ-005 SEARCH and EVAL: cam_search_enable_o=1 and cam_search_data_o=key_q; in all other states these outputs SHALL be 0.
REQ-006 In EVAL the engine SHALL sample cam_search_valid_i and cam_search_index_i, one cycle after search issue.
REQ-007 EVAL hit: rsp_hit_o=1, rsp_index_o=cam_search_index_i, then go to RESP with no CAM write.
REQ-008 EVAL miss: go to WRITE (allocation enabled, REQ-016) or RESP with rsp_hit_o=0 (allocation disabled).
REQ-009 WRITE lasts exactly one cycle. Outputs: cam_write_enable_o=1, cam_write_index_o=alloc_ptr, cam_write_data_o=key_q. Response fields: rsp_hit_o=0, rsp_index_o=alloc_ptr. Updates: alloc_ptr increments, occupancy_o increments unless already 32. Next state: RESP.
REQ-010 alloc_ptr SHALL wrap from 31 to 0; when full, allocation SHALL overwrite the oldest entry (FIFO replacement) and occupancy_o stays 32.
REQ-011 RESP: rsp_valid_o=1 with rsp_hit_o and rsp_index_o stable until rsp_valid_o&&rsp_ready_i, then return to IDLE.
REQ-012 Request-to-response latency SHALL be 3 cycles on a hit and 4 cycles on an allocating miss, measured from the accept edge to the first rsp_valid_o cycle.
REQ-013 req_ready_o SHALL be 0 outside IDLE; only one request is outstanding; no request is accepted in the cycle a response is consumed.
REQ-014 cam_write_enable_o SHALL be 0 in every state except WRITE; search and write are never asserted in the same cycle.

Reset
REQ-015 When rst_i is sampled high, in any state including mid-WRITE:
- state = IDLE, key_q = 0, alloc_ptr = 0, occupancy_o = 0
- rsp_valid_o, rsp_hit_o, rsp_index_o = 0
- all cam_* outputs = 0, so a pending write is aborted
- req_ready_o = 1 from the first cycle after reset deasserts

Configuration
REQ-016 Macro CAM_LOOKUP_AUTO_ALLOC_EN:
- Defined: misses allocate per REQ-009/010.
- Undefined: WRITE state absent; misses respond rsp_hit_o=0, rsp_index_o=0; cam_write_* tied 0; occupancy_o and full_o tied 0.

Structure
REQ-017 cam_pkg SHALL hold CAM_DEPTH, CAM_WIDTH, CAM_IDX_W and the FSM state enum typedef.
REQ-018 One sub-module, cam_alloc_ptr, SHALL hold the round-robin pointer and saturating occupancy counter; everything else is flat.

Verification
REQ-019 The bench SHALL pair the engine with the real CAM on shared clk/rst_i and cover:
- Key 0xDEADBEEF into empty CAM -> miss, rsp_index_o=0, occupancy_o=1; repeat -> hit, index 0, 3-cycle latency, no write pulse.
- 32 distinct keys 0x100..0x11F -> indices 0..31, full_o=1; key 0x200 -> miss, index 0; key 0x100 -> miss, index 1 (was evicted).
- rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and fields stable, req_ready_o=0 throughout; new req_valid_i ignored until handshake.
- rst_i pulsed during WRITE -> cam_write_enable_o=0 that cycle, occupancy_o=0; next lookup of the same key misses, index 0.
- Build without CAM_LOOKUP_AUTO_ALLOC_EN and lookup 0x1234 -> miss, index 0, no cam_write_enable_o pulse ever, occupancy_o=0.
